// File: rtl/lcd_rd_sched_if.sv
// Memory read port and pixel FIFO control bundle for the LCD read scheduler.
// master = scheduler side, slave = memory port / FIFO side.
interface lcd_rd_sched_if #(
  parameter int ADDR_W = 28,
  parameter int LVL_W  = 11
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_len;
  logic              rd_ack;
  logic              rd_done;
  logic              fifo_clr;
  logic              fifo_rd_en;
  logic [LVL_W-1:0]  fifo_level;

  modport master (
    output rd_req, rd_addr, rd_len, fifo_clr, fifo_rd_en,
    input  rd_ack, rd_done, fifo_level
  );

  modport slave (
    input  rd_req, rd_addr, rd_len, fifo_clr, fifo_rd_en,
    output rd_ack, rd_done, fifo_level
  );
endinterface

// File: rtl/lcd_rd_sched.sv
// Frame-buffer read scheduler for the RGB LCD path: flushes the pixel FIFO each frame
// and issues one-at-a-time burst reads. Define LCD_RD_UFCNT_EN to add the uf_cnt counter.
//
// state | meaning
// IDLE  | waiting for a frame start
// FLUSH | fifo_clr held for FLUSH_CYC cycles, frame parameters latched
// CHECK | decide: frame finished, room for a burst, or keep waiting
// REQ   | rd_req held with stable addr/len until rd_ack
// WAIT  | burst outstanding, waiting for rd_done
module lcd_rd_sched #(
  parameter int ADDR_W     = 28,
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 1024,
  parameter int LVL_W      = 11,
  parameter int FLUSH_CYC  = 8
) (
  input  logic              lcd_clk,
  input  logic              sys_rst_n,
  input  logic              out_vsync,
  input  logic              data_req,
  input  logic [10:0]       h_disp,
  input  logic [10:0]       v_disp,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              frame_busy,
  output logic              underflow,
`ifdef LCD_RD_UFCNT_EN
  output logic [15:0]       uf_cnt,
`endif
  lcd_rd_sched_if.master    bus
);

  localparam int FC_W = $clog2(FLUSH_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_CHECK,
    S_REQ,
    S_WAIT
  } state_t;

  state_t            state;
  logic              vsync_d;
  logic [FC_W-1:0]   flush_cnt;
  logic [ADDR_W-1:0] base_q;
  logic [20:0]       words_q;
  logic [20:0]       issued_q;
  logic              pend_q;
  logic              done_early_q;

  logic        frame_start;
  logic [20:0] frame_words_in;
  logic [20:0] remain;
  logic [7:0]  burst_len;
  logic        room_ok;
  logic        wait_done;
  logic        flush_go;
  logic        uf_hit;

  assign frame_start    = out_vsync & ~vsync_d;
  assign frame_words_in = 21'(h_disp) * 21'(v_disp);
  assign remain         = words_q - issued_q;
  assign burst_len      = (remain >= 21'(BURST_LEN)) ? 8'(BURST_LEN) : remain[7:0];
  assign room_ok        = (32'(bus.fifo_level) + 32'(BURST_LEN)) <= 32'(FIFO_DEPTH);
  // rd_done may arrive together with rd_ack; done_early_q remembers it for WAIT.
  assign wait_done      = bus.rd_done | done_early_q;

  always_comb begin
    flush_go = 1'b0;
    case (state)
      S_IDLE, S_CHECK: flush_go = frame_start;
      S_WAIT:          flush_go = wait_done & (pend_q | frame_start);
      default:         flush_go = 1'b0;
    endcase
  end

  assign uf_hit         = data_req & (bus.fifo_level == '0) & (state != S_FLUSH);
  assign bus.fifo_rd_en = data_req & (bus.fifo_level != '0) & (state != S_FLUSH);

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= S_IDLE;
      vsync_d      <= 1'b0;
      flush_cnt    <= '0;
      base_q       <= '0;
      words_q      <= '0;
      issued_q     <= '0;
      pend_q       <= 1'b0;
      done_early_q <= 1'b0;
      bus.fifo_clr <= 1'b0;
      bus.rd_req   <= 1'b0;
      bus.rd_addr  <= '0;
      bus.rd_len   <= '0;
      frame_busy   <= 1'b0;
    end else begin
      vsync_d <= out_vsync;
      if (flush_go) begin
        state        <= S_FLUSH;
        bus.fifo_clr <= 1'b1;
        flush_cnt    <= FC_W'(FLUSH_CYC - 1);
        base_q       <= frame_base;
        words_q      <= frame_words_in;
        issued_q     <= '0;
        pend_q       <= 1'b0;
        done_early_q <= 1'b0;
        frame_busy   <= 1'b1;
      end else begin
        case (state)
          S_IDLE: ;
          S_FLUSH: begin
            if (flush_cnt == '0) begin
              bus.fifo_clr <= 1'b0;
              state        <= S_CHECK;
            end else begin
              flush_cnt <= flush_cnt - 1'b1;
            end
          end
          S_CHECK: begin
            if (remain == '0) begin
              frame_busy <= 1'b0;
              state      <= S_IDLE;
            end else if (room_ok) begin
              bus.rd_addr <= base_q + ADDR_W'(issued_q);
              bus.rd_len  <= burst_len;
              bus.rd_req  <= 1'b1;
              state       <= S_REQ;
            end
          end
          S_REQ: begin
            if (frame_start) pend_q <= 1'b1;
            if (bus.rd_ack) begin
              bus.rd_req   <= 1'b0;
              issued_q     <= issued_q + 21'(bus.rd_len);
              done_early_q <= bus.rd_done;
              state        <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (frame_start) pend_q <= 1'b1;
            if (wait_done) begin
              done_early_q <= 1'b0;
              state        <= S_CHECK;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      underflow <= 1'b0;
    end else if (flush_go || state == S_FLUSH) begin
      underflow <= 1'b0;
    end else if (uf_hit) begin
      underflow <= 1'b1;
    end
  end

`ifdef LCD_RD_UFCNT_EN
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      uf_cnt <= '0;
    end else if (flush_go || state == S_FLUSH) begin
      uf_cnt <= '0;
    end else if (uf_hit && uf_cnt != 16'hFFFF) begin
      uf_cnt <= uf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_rd_sched.sv
// Scoreboard bench for lcd_rd_sched: a frame model predicts the burst list, a memory
// responder answers requests, and a monitor checks every presented request.
module tb_lcd_rd_sched;
  localparam int ADDR_W = 28;
  localparam int LVL_W  = 11;

  logic              lcd_clk   = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              out_vsync = 1'b0;
  logic              data_req  = 1'b0;
  logic [10:0]       h_disp    = '0;
  logic [10:0]       v_disp    = '0;
  logic [ADDR_W-1:0] frame_base = '0;
  logic              frame_busy;
  logic              underflow;
`ifdef LCD_RD_UFCNT_EN
  logic [15:0]       uf_cnt;
`endif

  lcd_rd_sched_if #(.ADDR_W(ADDR_W), .LVL_W(LVL_W)) bus ();

  lcd_rd_sched #(
    .ADDR_W(ADDR_W), .BURST_LEN(64), .FIFO_DEPTH(1024), .LVL_W(LVL_W), .FLUSH_CYC(8)
  ) dut (
    .lcd_clk    (lcd_clk),
    .sys_rst_n  (sys_rst_n),
    .out_vsync  (out_vsync),
    .data_req   (data_req),
    .h_disp     (h_disp),
    .v_disp     (v_disp),
    .frame_base (frame_base),
    .frame_busy (frame_busy),
    .underflow  (underflow),
`ifdef LCD_RD_UFCNT_EN
    .uf_cnt     (uf_cnt),
`endif
    .bus        (bus)
  );

  always #5 lcd_clk = ~lcd_clk;

  typedef struct {
    logic [27:0] addr;
    logic [7:0]  len;
  } burst_t;

  burst_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ack_dly = 1;
  int done_dly = 8;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int acc_cnt = 0;
  int req_seen = 0;
  int clr_run = 0;

  always @(posedge lcd_clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a frame is h*v words read in consecutive chunks of at most 64.
  function automatic int push_frame(input int h, input int v, input logic [27:0] base);
    int words;
    int nb;
    burst_t b;
    words = (h * v) & 32'h1F_FFFF;
    nb = 0;
    for (int off = 0; off < words; off += 64) begin
      b.addr = base + 28'(off);
      b.len  = 8'(((words - off) > 64) ? 64 : (words - off));
      exp_q.push_back(b);
      nb++;
    end
    return nb;
  endfunction

  // Memory port: ack after ack_dly cycles, rd_done done_dly cycles after the ack.
  initial begin : responder
    int k;
    bus.rd_ack  = 1'b0;
    bus.rd_done = 1'b0;
    forever begin
      @(negedge lcd_clk); #1;
      if (sys_rst_n && bus.rd_req) begin
        k = 0;
        while (k < ack_dly && sys_rst_n) begin @(negedge lcd_clk); #1; k++; end
        if (sys_rst_n) begin
          bus.rd_ack = 1'b1;
          if (done_dly == 0) begin
            bus.rd_done = 1'b1; done_cnt++; last_done_cyc = cyc;
          end
          @(negedge lcd_clk); #1;
          bus.rd_ack  = 1'b0;
          bus.rd_done = 1'b0;
          if (done_dly > 0) begin
            k = 1;
            while (k < done_dly && sys_rst_n) begin @(negedge lcd_clk); #1; k++; end
            if (sys_rst_n) begin
              bus.rd_done = 1'b1; done_cnt++; last_done_cyc = cyc;
              @(negedge lcd_clk); #1;
              bus.rd_done = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge lcd_clk); #2;
      if (!sys_rst_n) begin
        clr_run = 0;
      end else begin
        if (bus.fifo_clr) clr_run++;
        else if (clr_run > 0) begin
          check("fifo_clr_len", clr_run, 8);
          clr_run = 0;
        end
        if (bus.rd_req) begin
          req_seen++;
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_req: got addr 0x%0h len %0d, expected no request",
                     bus.rd_addr, bus.rd_len);
          end else begin
            check("rd_addr", bus.rd_addr, exp_q[0].addr);
            check("rd_len", bus.rd_len, exp_q[0].len);
            if (bus.rd_ack) begin
              void'(exp_q.pop_front());
              acc_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic wait_end(input int nb, input int d0);
    int t;
    int diff;
    t = 0;
    while (frame_busy && t < 4000) begin @(negedge lcd_clk); #3; t++; end
    if (t >= 4000) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_timeout: frame_busy still 1 after %0d cycles, expected 0", t);
    end
    check("bursts_done", done_cnt - d0, nb);
    check("exp_empty", exp_q.size(), 0);
    if (nb > 0) begin
      diff = cyc - last_done_cyc;
      n_cmp++;
      if (diff < 1 || diff > 3) begin
        n_bad++;
        $display("FAIL busy_fall: frame_busy fell %0d cycles after last rd_done, expected 1..3", diff);
      end
    end
  endtask

  task automatic run_frame(input int h, input int v, input logic [27:0] base);
    int nb;
    int d0;
    h_disp = 11'(h); v_disp = 11'(v); frame_base = base;
    nb = push_frame(h, v, base);
    d0 = done_cnt;
    out_vsync = 1'b1;
    @(negedge lcd_clk); #3;
    check("busy_rise", frame_busy, 1);
    check("fifo_clr_on", bus.fifo_clr, 1);
    check("uf_clr_flush", underflow, 0);
    if (data_req) check("rd_en_flush", bus.fifo_rd_en, 0);
`ifdef LCD_RD_UFCNT_EN
    check("ufcnt_clr_flush", uf_cnt, 0);
`endif
    @(negedge lcd_clk); @(negedge lcd_clk);
    out_vsync = 1'b0;
    wait_end(nb, d0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int nb;
    int d0;
    int r0;
    int t;
    bus.fifo_level = '0;
    #23;
    check("rst_fifo_clr", bus.fifo_clr, 0);
    check("rst_rd_req", bus.rd_req, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_rd_len", bus.rd_len, 0);
    check("rst_busy", frame_busy, 0);
    check("rst_underflow", underflow, 0);
    @(negedge lcd_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge lcd_clk);

    // Reference frame: four 64-word bursts then one of 44.
    ack_dly = 1; done_dly = 8;
    run_frame(100, 3, 28'h1000);

    // FIFO-room gating, and a frame start while stuck in CHECK.
    @(negedge lcd_clk);
    bus.fifo_level = 11'd980;
    h_disp = 11'd10; v_disp = 11'd1; frame_base = 28'h5000;
    void'(push_frame(10, 1, 28'h5000));
    r0 = req_seen;
    out_vsync = 1'b1; repeat (3) @(negedge lcd_clk); out_vsync = 1'b0;
    repeat (30) @(negedge lcd_clk);
    check("gate_no_req", req_seen - r0, 0);
    exp_q.delete();
    h_disp = 11'd20; frame_base = 28'h6000;
    nb = push_frame(20, 1, 28'h6000);
    d0 = done_cnt;
    out_vsync = 1'b1;
    @(negedge lcd_clk); #3;
    check("check_restart_clr", bus.fifo_clr, 1);
    @(negedge lcd_clk); @(negedge lcd_clk); out_vsync = 1'b0;
    repeat (15) @(negedge lcd_clk);
    check("gate_no_req2", req_seen - r0, 0);
    bus.fifo_level = 11'd960;
    @(negedge lcd_clk); #3;
    check("gate_release", bus.rd_req, 1);
    wait_end(nb, d0);
    bus.fifo_level = '0;

    // Frame start while a burst is outstanding.
    @(negedge lcd_clk);
    ack_dly = 1; done_dly = 20;
    h_disp = 11'd100; v_disp = 11'd3; frame_base = 28'h2000;
    void'(push_frame(100, 3, 28'h2000));
    r0 = acc_cnt;
    out_vsync = 1'b1; repeat (3) @(negedge lcd_clk); out_vsync = 1'b0;
    t = 0;
    while (acc_cnt == r0 && t < 200) begin @(negedge lcd_clk); #3; t++; end
    check("first_ack_seen", (acc_cnt > r0) ? 1 : 0, 1);
    repeat (2) @(negedge lcd_clk);
    d0 = done_cnt;
    frame_base = 28'h8000;
    exp_q.delete();
    nb = push_frame(100, 3, 28'h8000);
    out_vsync = 1'b1;
    t = 0;
    while (done_cnt == d0 && t < 100) begin
      @(negedge lcd_clk);
      if (t == 2) out_vsync = 1'b0;
      #3;
      if (done_cnt == d0) check("pend_no_req", bus.rd_req, 0);
      t++;
    end
    out_vsync = 1'b0;
    check("pend_done_seen", done_cnt - d0, 1);
    wait_end(nb, d0 + 1);

    // Underflow detection and clearing.
    @(negedge lcd_clk);
    done_dly = 3;
    bus.fifo_level = '0;
    data_req = 1'b1;
    #3 check("uf_before", underflow, 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge lcd_clk); #3; end
      check("rd_en_empty", bus.fifo_rd_en, 0);
    end
    @(negedge lcd_clk);
    data_req = 1'b0;
    #3 check("uf_set", underflow, 1);
`ifdef LCD_RD_UFCNT_EN
    check("uf_cnt3", uf_cnt, 3);
`endif
    @(negedge lcd_clk);
    bus.fifo_level = 11'd5;
    data_req = 1'b1;
    #3 check("rd_en_data", bus.fifo_rd_en, 1);
    check("uf_sticky", underflow, 1);
    @(negedge lcd_clk);
    run_frame(0, 5, 28'h100);
    check("uf_after_flush", underflow, 0);
    data_req = 1'b0;
    bus.fifo_level = '0;

    // Request held off for 50 cycles, then reset asserted mid-request.
    @(negedge lcd_clk);
    ack_dly = 200; done_dly = 4;
    h_disp = 11'd100; v_disp = 11'd3; frame_base = 28'h3000;
    void'(push_frame(100, 3, 28'h3000));
    out_vsync = 1'b1; repeat (3) @(negedge lcd_clk); out_vsync = 1'b0;
    t = 0;
    while (!bus.rd_req && t < 50) begin @(negedge lcd_clk); #3; t++; end
    for (int i = 0; i < 50; i++) begin
      @(negedge lcd_clk); #3;
      check("hold_req", bus.rd_req, 1);
    end
    sys_rst_n = 1'b0;
    #1;
    check("arst_fifo_clr", bus.fifo_clr, 0);
    check("arst_rd_req", bus.rd_req, 0);
    check("arst_rd_addr", bus.rd_addr, 0);
    check("arst_rd_len", bus.rd_len, 0);
    check("arst_busy", frame_busy, 0);
    check("arst_underflow", underflow, 0);
    check("arst_rd_en", bus.fifo_rd_en, 0);
    exp_q.delete();
    repeat (3) @(negedge lcd_clk);
    sys_rst_n = 1'b1;
    ack_dly = 2;
    r0 = req_seen;
    repeat (25) @(negedge lcd_clk);
    #3 check("post_rst_idle_req", req_seen - r0, 0);
    check("post_rst_idle_busy", frame_busy, 0);

    // Randomized frames, one with an address that wraps.
    for (int i = 0; i < 6; i++) begin
      logic [27:0] base;
      int h;
      int v;
      @(negedge lcd_clk);
      ack_dly  = $urandom_range(0, 3);
      done_dly = $urandom_range(0, 10);
      bus.fifo_level = 11'($urandom_range(0, 900));
      h = $urandom_range(1, 150);
      v = $urandom_range(0, 4);
      base = 28'($urandom);
      if (i == 2) begin base = 28'hFFF_FFC0; v = 2; end
      run_frame(h, v, base);
    end

    repeat (4) @(negedge lcd_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
